// File: rtl/spi_burst_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_burst_pkg
// Brief    : Shared types and defaults for the SPI burst controller.
// Revision : 1.0 - initial release
// ============================================================================
package spi_burst_pkg;

  localparam int unsigned C_DATA_WIDTH = 8;
  localparam int unsigned C_FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_e;

  // TX FIFO entry layout at the default byte width: last flag above the data.
  typedef struct packed {
    logic                    last;
    logic [C_DATA_WIDTH-1:0] data;
  } tx_entry_t;

endpackage
`default_nettype wire

// File: rtl/spi_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_burst_ctrl_if
// Brief    : Host-side FIFO handshakes plus SPI-master handshake of the burst controller.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_burst_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  tx_last_i;
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_valid_o;
  logic                  rx_ready_i;
  logic [DATA_WIDTH-1:0] spi_din_o;
  logic                  spi_start_o;
  logic [DATA_WIDTH-1:0] spi_dout_i;
  logic                  spi_done_tick_i;
  logic                  spi_ready_i;
  logic                  cs_n_o;
  logic                  busy_o;

  // The controller side.
  modport master (
    input  tx_data_i, tx_last_i, tx_valid_i, rx_ready_i,
    input  spi_dout_i, spi_done_tick_i, spi_ready_i,
    output tx_ready_o, rx_data_o, rx_valid_o,
    output spi_din_o, spi_start_o, cs_n_o, busy_o
  );

  // The host / SPI master side.
  modport slave (
    output tx_data_i, tx_last_i, tx_valid_i, rx_ready_i,
    output spi_dout_i, spi_done_tick_i, spi_ready_i,
    input  tx_ready_o, rx_data_o, rx_valid_o,
    input  spi_din_o, spi_start_o, cs_n_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/spi_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_fifo
// Brief    : Show-ahead synchronous FIFO with count-based full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             wr_en_i,
  input  wire logic [WIDTH-1:0] wr_data_i,
  input  wire logic             rd_en_i,
  output logic      [WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned C_AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned C_CW = C_AW + 1;
  localparam logic [C_CW-1:0] C_FULL = C_CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]  r_wr_ptr;
  logic [C_AW-1:0]  r_rd_ptr;
  logic [C_CW-1:0]  r_count;
  logic             w_wr;
  logic             w_rd;

  // Flags come from the registered count, so a write while full is dropped
  // even when a read happens in the same cycle.
  assign full_o    = (r_count == C_FULL);
  assign empty_o   = (r_count == '0);
  assign w_wr      = wr_en_i && !full_o;
  assign w_rd      = rd_en_i && !empty_o;
  assign rd_data_o = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_burst_ctrl
// Brief    : Feeds buffered TX bytes to a byte SPI master, collects RX bytes,
//            and frames each burst with chip select plus setup/hold spacing.
// Revision : 1.0 - initial release
// ============================================================================
module spi_burst_ctrl
  import spi_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = C_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH      = C_FIFO_DEPTH,
  parameter int unsigned CS_SETUP_CYCLES = 2,
  parameter int unsigned CS_HOLD_CYCLES  = 2
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  spi_burst_ctrl_if.master bus
);

  localparam int unsigned C_CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ?
                                      CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int unsigned C_CNT_W   = (C_CNT_MAX < 2) ? 1 : $clog2(C_CNT_MAX + 1);
  localparam logic [C_CNT_W-1:0] C_SETUP = C_CNT_W'(CS_SETUP_CYCLES);
  localparam logic [C_CNT_W-1:0] C_HOLD  = C_CNT_W'(CS_HOLD_CYCLES);

  state_e                r_state;
  logic [C_CNT_W-1:0]    r_cnt;
  logic                  r_last;
  logic                  r_cs_n;
  logic                  r_start;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_busy;

  logic [DATA_WIDTH:0]   w_tx_head;
  logic                  w_tx_full;
  logic                  w_tx_empty;
  logic                  w_tx_pop;
  logic                  w_rx_full;
  logic                  w_rx_empty;
  logic                  w_rx_push;
  logic                  w_issue_ok;

  spi_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (bus.tx_valid_i),
    .wr_data_i ({bus.tx_last_i, bus.tx_data_i}),
    .rd_en_i   (w_tx_pop),
    .rd_data_o (w_tx_head),
    .full_o    (w_tx_full),
    .empty_o   (w_tx_empty)
  );

  spi_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (w_rx_push),
    .wr_data_i (bus.spi_dout_i),
    .rd_en_i   (bus.rx_ready_i),
    .rd_data_o (bus.rx_data_o),
    .full_o    (w_rx_full),
    .empty_o   (w_rx_empty)
  );

  // Never start a byte whose reply would have nowhere to land.
  assign w_issue_ok = !w_tx_empty && bus.spi_ready_i && !w_rx_full;
  assign w_tx_pop   = (r_state == ISSUE) && w_issue_ok;
  assign w_rx_push  = (r_state == WAIT) && bus.spi_done_tick_i;

  assign bus.tx_ready_o  = !w_tx_full;
  assign bus.rx_valid_o  = !w_rx_empty;
  assign bus.spi_din_o   = r_din;
  assign bus.spi_start_o = r_start;
  assign bus.cs_n_o      = r_cs_n;
  assign bus.busy_o      = r_busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_start <= 1'b0;
      r_din   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_tx_empty) begin
            r_cs_n  <= 1'b0;
            r_cnt   <= C_SETUP;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            r_state <= ISSUE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ISSUE: begin
          // Stalls here with cs_n held low on TX underrun or RX backpressure.
          if (w_issue_ok) begin
            r_din   <= w_tx_head[DATA_WIDTH-1:0];
            r_last  <= w_tx_head[DATA_WIDTH];
            r_start <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.spi_done_tick_i) begin
            if (r_last) begin
              r_cnt   <= C_HOLD;
              r_state <= HOLD;
            end else begin
              r_state <= ISSUE;
            end
          end
        end
        HOLD: begin
          if (r_cnt == '0) begin
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_burst_ctrl
// Brief    : Directed and randomized self-checking bench for spi_burst_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_burst_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int BOUND = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_burst_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  spi_burst_ctrl #(
    .DATA_WIDTH      (DW),
    .FIFO_DEPTH      (DEPTH),
    .CS_SETUP_CYCLES (SETUP),
    .CS_HOLD_CYCLES  (HOLD)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: bytes expected on din in order, replies expected on RX in order.
  spi_burst_pkg::tx_entry_t exp_tx[$];
  logic [DW-1:0]            exp_rx[$];

  int            cyc         = 0;
  int            cyc_done    = -100;
  int            cyc_cs_rise = -100;
  int            n_start     = 0;
  int            n_cs_rise   = 0;
  bit            slave_en    = 1'b1;
  bit            chk_spacing = 1'b0;
  bit            use_fixed   = 1'b0;
  logic [DW-1:0] fixed_resp  = '0;
  int            lat_fix     = 0;

  int                       sl_busy  = 0;
  logic [DW-1:0]            sl_resp  = '0;
  bit                       sl_plast = 1'b1;
  logic                     sl_pcs   = 1'b1;
  spi_burst_pkg::tx_entry_t sl_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed timeout expected event within %0d cycles", tag, BOUND);
  endtask

  // SPI master model: accepts a start, answers after a latency with a reply byte.
  initial begin
    bus.spi_done_tick_i = 1'b0;
    bus.spi_dout_i      = '0;
    bus.spi_ready_i     = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      bus.spi_done_tick_i = 1'b0;
      if (sl_pcs === 1'b0 && bus.cs_n_o === 1'b1) begin
        n_cs_rise++;
        cyc_cs_rise = cyc;
      end
      sl_pcs = bus.cs_n_o;
      if (sl_busy > 0) begin
        sl_busy--;
        if (sl_busy == 0) begin
          bus.spi_done_tick_i = 1'b1;
          bus.spi_dout_i      = sl_resp;
          bus.spi_ready_i     = slave_en;
          cyc_done            = cyc;
        end
      end else if (bus.spi_start_o === 1'b1) begin
        n_start++;
        n_cmp++;
        assert (exp_tx.size() != 0) else begin
          n_err++;
          $error("FAIL start_expected: observed start with din %0h expected no start", bus.spi_din_o);
        end
        if (exp_tx.size() != 0) begin
          sl_e = exp_tx.pop_front();
          chk("start_din", bus.spi_din_o, sl_e.data);
          chk("start_cs_low", bus.cs_n_o, 0);
          if (chk_spacing && !sl_plast) chk("start_spacing", cyc - cyc_done, 2);
          sl_plast = sl_e.last;
        end
        sl_resp = use_fixed ? fixed_resp : DW'($urandom);
        exp_rx.push_back(sl_resp);
        sl_busy = (lat_fix > 0) ? lat_fix : int'($urandom_range(4, 1));
        bus.spi_ready_i = 1'b0;
      end else begin
        bus.spi_ready_i = slave_en;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] d, input bit last);
    int t;
    spi_burst_pkg::tx_entry_t e;
    t = 0;
    while (bus.tx_ready_o !== 1'b1 && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    if (t >= BOUND) timeout("push_ready");
    bus.tx_data_i  = d;
    bus.tx_last_i  = last;
    bus.tx_valid_i = 1'b1;
    e.data = d;
    e.last = last;
    exp_tx.push_back(e);
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
  endtask

  task automatic drain(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (bus.rx_valid_o !== 1'b1 && t < BOUND) begin
        @(negedge clk);
        t++;
      end
      if (t >= BOUND) begin
        timeout("rx_valid");
      end else if (exp_rx.size() == 0) begin
        timeout("rx_model_empty");
      end else begin
        chk("rx_data", bus.rx_data_o, exp_rx.pop_front());
      end
      bus.rx_ready_i = 1'b1;
      @(negedge clk);
      bus.rx_ready_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    tick(2);
    t = 0;
    while (bus.busy_o !== 1'b0 && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    if (t >= BOUND) timeout("wait_idle");
    tick(1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int r0;
    int len;
    int acc;
    bus.tx_data_i  = '0;
    bus.tx_last_i  = 1'b0;
    bus.tx_valid_i = 1'b0;
    bus.rx_ready_i = 1'b0;

    // Reset values
    rst = 1'b1;
    tick(3);
    chk("rst_cs_n", bus.cs_n_o, 1);
    chk("rst_start", bus.spi_start_o, 0);
    chk("rst_din", bus.spi_din_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_tx_ready", bus.tx_ready_o, 1);
    chk("rst_rx_valid", bus.rx_valid_o, 0);
    rst = 1'b0;
    tick(2);

    // Single byte with a fixed reply
    use_fixed  = 1'b1;
    fixed_resp = 8'h3C;
    s0 = n_start;
    push(8'hA5, 1'b1);
    wait_idle();
    chk("single_starts", n_start - s0, 1);
    // cs_n releases HOLD+1 edges after the edge that consumes the done tick.
    chk("single_cs_hold", cyc_cs_rise - (cyc_done + 1), HOLD + 1);
    chk("single_cs_high", bus.cs_n_o, 1);
    chk("single_busy", bus.busy_o, 0);
    chk("single_rx_valid", bus.rx_valid_o, 1);
    chk("single_rx_data", bus.rx_data_o, 8'h3C);
    drain(1);
    use_fixed = 1'b0;

    // Fixed three-byte burst
    chk_spacing = 1'b1;
    s0 = n_start;
    r0 = n_cs_rise;
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b1);
    wait_idle();
    chk("burst_starts", n_start - s0, 3);
    chk("burst_cs_rises", n_cs_rise - r0, 1);
    drain(3);

    // Randomized bursts
    for (int b = 0; b < 6; b++) begin
      len = int'($urandom_range(5, 1));
      s0 = n_start;
      r0 = n_cs_rise;
      for (int i = 0; i < len; i++) push(DW'($urandom), i == len - 1);
      wait_idle();
      chk("rand_starts", n_start - s0, len);
      chk("rand_cs_rises", n_cs_rise - r0, 1);
      drain(len);
    end
    chk_spacing = 1'b0;

    // RX backpressure: more bytes than RX can hold
    s0 = n_start;
    r0 = n_cs_rise;
    for (int i = 0; i < DEPTH + 2; i++) push(DW'(8'h40 + i), i == DEPTH + 1);
    tick(30);
    chk("bp_starts_stalled", n_start - s0, DEPTH);
    chk("bp_cs_low", bus.cs_n_o, 0);
    chk("bp_busy", bus.busy_o, 1);
    drain(DEPTH + 2);
    wait_idle();
    chk("bp_starts_total", n_start - s0, DEPTH + 2);
    chk("bp_cs_rises", n_cs_rise - r0, 1);

    // TX full with the master never ready
    slave_en = 1'b0;
    tick(2);
    s0  = n_start;
    acc = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      chk("full_tx_ready", bus.tx_ready_o, (acc < DEPTH) ? 1 : 0);
      bus.tx_data_i  = DW'(8'h80 + i);
      bus.tx_last_i  = (i >= DEPTH - 1);
      bus.tx_valid_i = 1'b1;
      if (acc < DEPTH) begin
        spi_burst_pkg::tx_entry_t e;
        e.data = DW'(8'h80 + i);
        e.last = (i >= DEPTH - 1);
        exp_tx.push_back(e);
        acc++;
      end
      @(negedge clk);
    end
    bus.tx_valid_i = 1'b0;
    tick(5);
    chk("full_no_start", n_start - s0, 0);
    chk("full_tx_ready_after", bus.tx_ready_o, 0);
    slave_en = 1'b1;
    wait_idle();
    chk("full_starts", n_start - s0, DEPTH);
    drain(DEPTH);

    // TX underrun mid-burst
    s0 = n_start;
    r0 = n_cs_rise;
    push(8'h55, 1'b0);
    tick(20);
    chk("under_cs_low", bus.cs_n_o, 0);
    chk("under_busy", bus.busy_o, 1);
    chk("under_starts", n_start - s0, 1);
    chk("under_rx_valid", bus.rx_valid_o, 1);
    push(8'h66, 1'b1);
    wait_idle();
    chk("under_starts_total", n_start - s0, 2);
    chk("under_cs_rises", n_cs_rise - r0, 1);
    drain(2);

    // Reset while waiting for the done tick
    lat_fix = 6;
    s0 = n_start;
    push(8'h77, 1'b1);
    begin
      int t;
      t = 0;
      while (n_start == s0 && t < BOUND) begin
        @(negedge clk);
        t++;
      end
      if (t >= BOUND) timeout("rst_wait_start");
    end
    tick(1);
    rst = 1'b1;
    #1;
    chk("midrst_cs_n", bus.cs_n_o, 1);
    chk("midrst_start", bus.spi_start_o, 0);
    chk("midrst_rx_valid", bus.rx_valid_o, 0);
    chk("midrst_busy", bus.busy_o, 0);
    exp_tx.delete();
    exp_rx.delete();
    tick(2);
    rst = 1'b0;
    tick(10);
    chk("late_done_rx_valid", bus.rx_valid_o, 0);
    chk("late_done_busy", bus.busy_o, 0);
    chk("late_done_cs_n", bus.cs_n_o, 1);
    lat_fix = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
